regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: picks one of NUM_REQ requesters and streams its beats
// into the register file, one write per accepted beat, with registered write outputs.
// A burst ends on req_last or after BURST_MAX beats. Beats to register 0 are consumed
// without a write strobe.
// Build option: define REGFILE_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins).
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic                    write_enable,
  output logic [4:0]              write_addr,
  output logic [31:0]             write_data,
  output logic [1:0]              grant_id,
  output logic                    busy,
  output logic                    burst_err
);

  localparam int NReq = int'(NUM_REQ);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e      state_q;
  logic [5:0]  beat_cnt_q;
  logic [4:0]  next_addr_q;
  logic [1:0]  owner_q;
  logic        write_enable_q;
  logic [4:0]  write_addr_q;
  logic [31:0] write_data_q;
  logic        burst_err_q;

  logic [1:0]  winner;
  logic [1:0]  sel;
  logic [4:0]  sel_addr;
  logic [4:0]  beat_addr;
  logic [31:0] beat_data;
  logic        beat_last;
  logic        accept;
  logic [5:0]  cnt_next;
  logic        burst_end;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic [1:0]  rr_ptr_q;
  logic        found;

  // Round-robin pick: first valid requester searching upward from the last owner + 1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NReq; k++) begin
      for (int j = 0; j < NReq; j++) begin
        if (!found && req_valid[j] && (j == (int'(rr_ptr_q) + 1 + k) % NReq)) begin
          winner = 2'(j);
          found  = 1'b1;
        end
      end
    end
  end
`else
  // Fixed-priority pick: lowest valid index wins.
  always_comb begin
    winner = '0;
    for (int j = NReq - 1; j >= 0; j--) begin
      if (req_valid[j]) winner = 2'(j);
    end
  end
`endif

  // Select the active requester's beat and decide acceptance / burst termination.
  always_comb begin
    sel       = (state_q == StIdle) ? winner : owner_q;
    sel_addr  = '0;
    beat_data = '0;
    beat_last = 1'b0;
    req_ready = '0;
    for (int j = 0; j < NReq; j++) begin
      if (sel == 2'(j)) begin
        sel_addr  = req_addr[5*j +: 5];
        beat_data = req_data[32*j +: 32];
        beat_last = req_last[j];
        // In IDLE the winner is valid whenever anyone is, so one rule covers both states.
        req_ready[j] = req_valid[j] & ~rst;
      end
    end
    // Only the first beat of a burst takes the requester's address.
    beat_addr = (state_q == StIdle) ? sel_addr : next_addr_q;
    accept    = |req_ready;
    cnt_next  = (state_q == StIdle) ? 6'd1 : beat_cnt_q + 6'd1;
    burst_end = accept && (beat_last || (cnt_next == 6'(BURST_MAX)));
  end

  // Burst FSM with registered write port, grant and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      beat_cnt_q     <= '0;
      next_addr_q    <= '0;
      owner_q        <= '0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      burst_err_q    <= 1'b0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      rr_ptr_q       <= 2'(NUM_REQ - 1);
`endif
    end else begin
      write_enable_q <= accept && (beat_addr != 5'd0);
      burst_err_q    <= burst_end && !beat_last;
      if (accept) begin
        write_addr_q <= beat_addr;
        write_data_q <= beat_data;
        next_addr_q  <= beat_addr + 5'd1;
        if (state_q == StIdle) owner_q <= winner;
      end
      if (burst_end) begin
        state_q    <= StIdle;
        beat_cnt_q <= '0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        rr_ptr_q   <= sel;
`endif
      end else if (accept) begin
        state_q    <= StBurst;
        beat_cnt_q <= cnt_next;
      end
    end
  end

  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign grant_id     = owner_q;
  assign busy         = (state_q == StBurst);
  assign burst_err    = burst_err_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, hand sequences for bursts,
// contention, truncation and reset, then random traffic against a transaction model.
module tb_regfile_wr_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int BURST_MAX = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [5*NUM_REQ-1:0]  req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic                  write_enable;
  logic [4:0]            write_addr;
  logic [31:0]           write_data;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  burst_err;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_last    (req_last),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .burst_err   (burst_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model state.
  int          m_burst = 0;
  int          m_owner = 0;
  int          m_beats = 0;
  int          m_ptr   = NUM_REQ - 1;
  logic [4:0]  m_next  = '0;
  int          e_we = 0, e_wa = 0, e_grant = 0, e_busy = 0, e_err = 0;
  logic [31:0] e_wd = '0;
  logic [NUM_REQ-1:0] ready_seen;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == (m_ptr + 1 + k) % NUM_REQ && req_valid[j]) return j;
      end
    end
`else
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_valid[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic l);
    req_valid[i]       = v;
    req_addr[5*i +: 5] = a;
    req_data[32*i +: 32] = d;
    req_last[i]        = l;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_last  = '0;
  endtask

  // One clock: check ready against the model, advance the model, check registered outputs.
  task automatic step();
    logic [NUM_REQ-1:0] exp_ready;
    int                 idx;
    int                 w;
    logic [4:0]         addr;
    #1;
    exp_ready = '0;
    idx = -1;
    if (!rst) begin
      if (m_burst == 0) begin
        w = pick();
        for (int j = 0; j < NUM_REQ; j++) if (j == w) begin exp_ready[j] = 1'b1; idx = j; end
      end else begin
        for (int j = 0; j < NUM_REQ; j++)
          if (j == m_owner && req_valid[j]) begin exp_ready[j] = 1'b1; idx = j; end
      end
    end
    ready_seen = req_ready;
    check("req_ready", req_ready, exp_ready);
    if (rst) begin
      m_burst = 0; m_beats = 0; m_ptr = NUM_REQ - 1; m_owner = 0; m_next = '0;
      e_we = 0; e_wa = 0; e_wd = '0; e_grant = 0; e_err = 0;
    end else if (idx >= 0) begin
      addr = (m_burst != 0) ? m_next : req_addr[5*idx +: 5];
      e_we = (addr != 5'd0) ? 1 : 0;
      e_wa = addr;
      e_wd = req_data[32*idx +: 32];
      if (m_burst == 0) begin m_owner = idx; e_grant = idx; m_beats = 0; end
      m_beats++;
      if (req_last[idx] || m_beats == BURST_MAX) begin
        e_err = req_last[idx] ? 0 : 1;
        m_burst = 0;
        m_beats = 0;
        m_ptr = idx;
      end else begin
        e_err = 0;
        m_burst = 1;
        m_next = addr + 5'd1;
      end
    end else begin
      e_we = 0;
      e_err = 0;
    end
    e_busy = m_burst;
    @(posedge clk);
    #1;
    check("write_enable", write_enable, e_we);
    check("write_addr", write_addr, e_wa);
    check("write_data", write_data, e_wd);
    check("grant_id", grant_id, e_grant);
    check("busy", busy, e_busy);
    check("burst_err", burst_err, e_err);
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_wa_seq[4];
    int exp_we_seq[4];
    int exp_busy_seq[4];
    logic [2:0] exp_rdy_seq[4];

    tbl[0] = '{3'b001, 5'd5,  32'hDEAD_BEEF, 3'b001, 1'b1, 5'd5,  32'hDEAD_BEEF};
    tbl[1] = '{3'b010, 5'd10, 32'h1234_5678, 3'b010, 1'b1, 5'd11, 32'h1234_5679};
    tbl[2] = '{3'b100, 5'd0,  32'hA5A5_A5A5, 3'b100, 1'b1, 5'd2,  32'hA5A5_A5A7};
    tbl[3] = '{3'b001, 5'd0,  32'h0BAD_F00D, 3'b001, 1'b0, 5'd0,  32'h0BAD_F00D};
    tbl[4] = '{3'b000, 5'd9,  32'hFFFF_FFFF, 3'b000, 1'b0, 5'd0,  32'h0BAD_F00D};
    tbl[5] = '{3'b100, 5'd29, 32'h0000_0100, 3'b100, 1'b1, 5'd31, 32'h0000_0102};
    tbl[6] = '{3'b011, 5'd3,  32'h1111_0000, 3'b001, 1'b1, 5'd3,  32'h1111_0000};
    tbl[7] = '{3'b110, 5'd7,  32'h2222_0000, 3'b010, 1'b1, 5'd8,  32'h2222_0001};

    clear_reqs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Directed single-beat vectors.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, tbl[k].valid[i], tbl[k].addr + 5'(i), tbl[k].data ^ 32'(i), 1'b1);
      step();
      check($sformatf("tbl%0d_ready", k), ready_seen, tbl[k].exp_ready);
      check($sformatf("tbl%0d_we", k), write_enable, tbl[k].exp_we);
      check($sformatf("tbl%0d_wa", k), write_addr, tbl[k].exp_wa);
      check($sformatf("tbl%0d_wd", k), write_data, tbl[k].exp_wd);
    end

    // Burst wrapping through register 0.
    do_reset();
    exp_wa_seq   = '{30, 31, 0, 1};
    exp_we_seq   = '{1, 1, 0, 1};
    exp_busy_seq = '{1, 1, 1, 0};
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1'b1, (b == 0) ? 5'd30 : 5'd17, 32'h100 + 32'(b), (b == 3));
      step();
      check("wrap_wa", write_addr, exp_wa_seq[b]);
      check("wrap_we", write_enable, exp_we_seq[b]);
      check("wrap_busy", busy, exp_busy_seq[b]);
    end
    check("wrap_grant", grant_id, 1);

    // Contention between two single-beat requesters.
    do_reset();
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    exp_rdy_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
`else
    exp_rdy_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    set_req(0, 1'b1, 5'd4, 32'hAAAA_0000, 1'b1);
    set_req(1, 1'b1, 5'd6, 32'hBBBB_0000, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      check("contend_ready", ready_seen, exp_rdy_seq[c]);
    end

    // Truncation at BURST_MAX, then re-arbitration of the remainder.
    do_reset();
    for (int b = 1; b <= 10; b++) begin
      set_req(2, 1'b1, 5'd4, 32'(b), 1'b0);
      step();
      check("trunc_wa", write_addr, (b <= 8) ? 4 + b - 1 : 4 + b - 9);
      check("trunc_err", burst_err, (b == 8) ? 1 : 0);
      check("trunc_busy", busy, (b == 8) ? 0 : 1);
    end
    clear_reqs();
    step();
    check("hold_busy", busy, 1);
    check("hold_we", write_enable, 0);
    check("hold_wa", write_addr, 5);

    // Reset in the middle of a burst with other requesters pending.
    do_reset();
    set_req(1, 1'b1, 5'd20, 32'h1, 1'b1);
    set_req(2, 1'b1, 5'd21, 32'h2, 1'b1);
    for (int b = 0; b < 3; b++) begin
      set_req(0, 1'b1, 5'd12, 32'hC0 + 32'(b), 1'b0);
      step();
      check("mid_ready", ready_seen, 3'b001);
    end
    rst = 1'b1;
    step();
    check("rst_ready", ready_seen, 3'b000);
    check("rst_busy", busy, 0);
    check("rst_we", write_enable, 0);
    check("rst_wa", write_addr, 0);
    rst = 1'b0;
    set_req(0, 1'b1, 5'd13, 32'hC9, 1'b1);
    step();
    check("post_rst_ready", ready_seen, 3'b001);
    check("post_rst_wa", write_addr, 13);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, $urandom_range(0, 3) != 0, 5'($urandom), $urandom,
                $urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
